// File: rtl/rtr_cfg_pkg.sv
// Purpose: shared port encoding, FSM state type and XY route function for the table sequencer.
// Latency: none (types and a pure combinational function).
// Backpressure: n/a.
package rtr_cfg_pkg;

    // Router output port encoding as stored in the routing tables.
    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_N     = 3'd1;
    localparam logic [2:0] PORT_S     = 3'd2;
    localparam logic [2:0] PORT_E     = 3'd3;
    localparam logic [2:0] PORT_W     = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cfg_state_t;

    // Dimension-ordered (column first) route from a source router to a destination.
    // A move that would leave the mesh falls back to PORT_N, which is the table's
    // encoding for "no legal hop"; with in-range coordinates those branches never fire.
    function automatic logic [2:0] xy_port(input int src_row, input int src_col,
                                           input int dst_row, input int dst_col,
                                           input int rows,    input int cols);
        logic [2:0] p;
        if ((dst_row == src_row) && (dst_col == src_col))
            p = PORT_LOCAL;
        else if (dst_col < src_col)
            p = (src_col == 0) ? PORT_N : PORT_W;
        else if (dst_col > src_col)
            p = (src_col == cols - 1) ? PORT_N : PORT_E;
        else if (dst_row < src_row)
            p = PORT_N;
        else
            p = (src_row == rows - 1) ? PORT_N : PORT_S;
        return p;
    endfunction

endpackage

// File: rtl/rtr_table_cfg_ctrl_if.sv
// Purpose: config-entry bus from the table sequencer to the fabric config decoder.
// Latency: none (wires only).
// Backpressure: valid/ready; master holds all payload fields while valid & !ready.
// Signals: cfg_valid, cfg_ready, cfg_rtr_addr {row,col}, cfg_dst_idx (row*cols+col),
//          cfg_port (route entry), cfg_last (final entry of the current router).
interface rtr_table_cfg_ctrl_if #(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int NUM_OUTPUTS = 5,
    parameter int ROUTE_WIDTH = $clog2(NUM_OUTPUTS)
);
    localparam int RTR_ADDR_WIDTH = $clog2(NUM_ROWS) + $clog2(NUM_COLS);
    localparam int IDX_WIDTH      = $clog2(NUM_ROWS * NUM_COLS);

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [RTR_ADDR_WIDTH-1:0] cfg_rtr_addr;
    logic [IDX_WIDTH-1:0]      cfg_dst_idx;
    logic [ROUTE_WIDTH-1:0]    cfg_port;
    logic                      cfg_last;

    modport master (
        output cfg_valid, cfg_rtr_addr, cfg_dst_idx, cfg_port, cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_rtr_addr, cfg_dst_idx, cfg_port, cfg_last,
        output cfg_ready
    );

endinterface

// File: rtl/rtr_xy_port_calc.sv
// Purpose: combinational XY output-port lookup for one (source, destination) router pair.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: src_row/src_col, dst_row/dst_col in; port out (ROUTE_WIDTH).
module rtr_xy_port_calc
    import rtr_cfg_pkg::*;
#(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int ROUTE_WIDTH = 3,
    parameter int ROW_WIDTH   = $clog2(NUM_ROWS),
    parameter int COL_WIDTH   = $clog2(NUM_COLS)
) (
    input  logic [ROW_WIDTH-1:0]   src_row,
    input  logic [COL_WIDTH-1:0]   src_col,
    input  logic [ROW_WIDTH-1:0]   dst_row,
    input  logic [COL_WIDTH-1:0]   dst_col,
    output logic [ROUTE_WIDTH-1:0] port
);

    logic [2:0] port_full;

    always_comb begin
        port_full = xy_port(int'(src_row), int'(src_col), int'(dst_row), int'(dst_col),
                            NUM_ROWS, NUM_COLS);
    end

    assign port = ROUTE_WIDTH'(port_full);

endmodule

// File: rtl/rtr_table_cfg_ctrl.sv
// Purpose: after start, emits one XY routing-table entry per (source router, destination) pair.
// Latency: first entry valid the cycle after start; 1 entry/cycle with ready high; done 1 cycle after last.
// Backpressure: cfg_ready low stalls the walk; all cfg_* fields hold while valid & !ready.
// Ports: clk, rst_n, start, abort in; busy, done out; cfg (master) carries the entry bus.
module rtr_table_cfg_ctrl
    import rtr_cfg_pkg::*;
#(
    parameter int NUM_ROWS    = 2,
    parameter int NUM_COLS    = 2,
    parameter int NUM_OUTPUTS = 5,
    parameter int ROUTE_WIDTH = $clog2(NUM_OUTPUTS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    rtr_table_cfg_ctrl_if.master cfg
);

    localparam int ROW_WIDTH      = $clog2(NUM_ROWS);
    localparam int COL_WIDTH      = $clog2(NUM_COLS);
    localparam int RTR_ADDR_WIDTH = ROW_WIDTH + COL_WIDTH;
    localparam int IDX_WIDTH      = $clog2(NUM_ROWS * NUM_COLS);

    // Full-width wrap points; counters never exceed these, even for non-power-of-2 meshes.
    localparam logic [ROW_WIDTH-1:0] ROW_MAX = ROW_WIDTH'(NUM_ROWS - 1);
    localparam logic [COL_WIDTH-1:0] COL_MAX = COL_WIDTH'(NUM_COLS - 1);

    cfg_state_t           state;
    logic [ROW_WIDTH-1:0] src_row;
    logic [COL_WIDTH-1:0] src_col;
    logic [ROW_WIDTH-1:0] dst_row;
    logic [COL_WIDTH-1:0] dst_col;

    logic                   running;
    logic                   handshake;
    logic                   dst_col_wrap;
    logic                   dst_row_wrap;
    logic                   src_col_wrap;
    logic                   src_row_wrap;
    logic                   last_entry;
    logic [ROUTE_WIDTH-1:0] port;

    assign running      = (state == RUN);
    assign handshake    = running && cfg.cfg_ready;
    assign dst_col_wrap = (dst_col == COL_MAX);
    assign dst_row_wrap = (dst_row == ROW_MAX);
    assign src_col_wrap = (src_col == COL_MAX);
    assign src_row_wrap = (src_row == ROW_MAX);
    assign last_entry   = dst_col_wrap && dst_row_wrap && src_col_wrap && src_row_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_row <= '0;
            src_col <= '0;
            dst_row <= '0;
            dst_col <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort beats a simultaneous start
                    if (start && !abort) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= IDLE;
                        src_row <= '0;
                        src_col <= '0;
                        dst_row <= '0;
                        dst_col <= '0;
                    end else if (handshake) begin
                        // Row-major odometer: dst_col fastest, src_row slowest.
                        // The final entry wraps every counter back to zero on its own.
                        dst_col <= dst_col_wrap ? '0 : dst_col + COL_WIDTH'(1);
                        if (dst_col_wrap) begin
                            dst_row <= dst_row_wrap ? '0 : dst_row + ROW_WIDTH'(1);
                            if (dst_row_wrap) begin
                                src_col <= src_col_wrap ? '0 : src_col + COL_WIDTH'(1);
                                if (src_col_wrap) begin
                                    src_row <= src_row_wrap ? '0 : src_row + ROW_WIDTH'(1);
                                end
                            end
                        end
                        if (last_entry) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start and abort are both ignored here; the done pulse always completes
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rtr_xy_port_calc #(
        .NUM_ROWS    (NUM_ROWS),
        .NUM_COLS    (NUM_COLS),
        .ROUTE_WIDTH (ROUTE_WIDTH),
        .ROW_WIDTH   (ROW_WIDTH),
        .COL_WIDTH   (COL_WIDTH)
    ) u_port_calc (
        .src_row (src_row),
        .src_col (src_col),
        .dst_row (dst_row),
        .dst_col (dst_col),
        .port    (port)
    );

    // Payload is driven straight from the counters, so it is stable across stalls and
    // is all-zero whenever the FSM is idle (counters are cleared on every exit from RUN).
    assign busy             = running;
    assign done             = (state == DONE);
    assign cfg.cfg_valid    = running;
    assign cfg.cfg_rtr_addr = RTR_ADDR_WIDTH'({src_row, src_col});
    assign cfg.cfg_dst_idx  = IDX_WIDTH'(int'(dst_row) * NUM_COLS + int'(dst_col));
    assign cfg.cfg_port     = port;
    assign cfg.cfg_last     = running && dst_row_wrap && dst_col_wrap;

endmodule

// File: tb/tb_rtr_table_cfg_ctrl.sv
module tb_rtr_table_cfg_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // index 0: 2x2 mesh, index 1: 3x4 mesh
    int R  [2] = '{2, 3};
    int C  [2] = '{2, 4};
    int CW [2] = '{1, 2};

    logic start [2] = '{1'b0, 1'b0};
    logic abort [2] = '{1'b0, 1'b0};
    logic ready [2] = '{1'b0, 1'b0};

    logic busy_a, done_a, busy_b, done_b;
    logic       o_valid [2];
    logic       o_last  [2];
    logic       o_busy  [2];
    logic       o_done  [2];
    logic [7:0] o_addr  [2];
    logic [7:0] o_idx   [2];
    logic [7:0] o_port  [2];

    rtr_table_cfg_ctrl_if #(.NUM_ROWS(2), .NUM_COLS(2), .NUM_OUTPUTS(5), .ROUTE_WIDTH(3)) if_a ();
    rtr_table_cfg_ctrl_if #(.NUM_ROWS(3), .NUM_COLS(4), .NUM_OUTPUTS(5), .ROUTE_WIDTH(3)) if_b ();

    rtr_table_cfg_ctrl #(.NUM_ROWS(2), .NUM_COLS(2), .NUM_OUTPUTS(5), .ROUTE_WIDTH(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start[0]),
        .abort (abort[0]),
        .busy  (busy_a),
        .done  (done_a),
        .cfg   (if_a.master)
    );

    rtr_table_cfg_ctrl #(.NUM_ROWS(3), .NUM_COLS(4), .NUM_OUTPUTS(5), .ROUTE_WIDTH(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start[1]),
        .abort (abort[1]),
        .busy  (busy_b),
        .done  (done_b),
        .cfg   (if_b.master)
    );

    assign if_a.cfg_ready = ready[0];
    assign if_b.cfg_ready = ready[1];

    assign o_valid[0] = if_a.cfg_valid;
    assign o_last[0]  = if_a.cfg_last;
    assign o_addr[0]  = 8'(if_a.cfg_rtr_addr);
    assign o_idx[0]   = 8'(if_a.cfg_dst_idx);
    assign o_port[0]  = 8'(if_a.cfg_port);
    assign o_busy[0]  = busy_a;
    assign o_done[0]  = done_a;
    assign o_valid[1] = if_b.cfg_valid;
    assign o_last[1]  = if_b.cfg_last;
    assign o_addr[1]  = 8'(if_b.cfg_rtr_addr);
    assign o_idx[1]   = 8'(if_b.cfg_dst_idx);
    assign o_port[1]  = 8'(if_b.cfg_port);
    assign o_busy[1]  = busy_b;
    assign o_done[1]  = done_b;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // XY route from the rules: move horizontally first, then vertically; a hop that
    // would leave the mesh is encoded as port 1.
    function automatic int ref_port(input int sr, input int sc, input int dr, input int dc,
                                    input int rows, input int cols);
        int dx, dy;
        dx = dc - sc;
        dy = dr - sr;
        if (dx == 0 && dy == 0) return 0;
        if (dx < 0) return (sc == 0) ? 1 : 4;
        if (dx > 0) return (sc == cols - 1) ? 1 : 3;
        if (dy < 0) return 1;
        return (sr == rows - 1) ? 1 : 2;
    endfunction

    // Behavioural model: m_k is the number of entries accepted so far in the current run.
    bit m_run  [2];
    bit m_done [2];
    int m_k    [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i]  <= 1'b0;
                m_done[i] <= 1'b0;
                m_k[i]    <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    m_done[i] <= 1'b0;
                end else if (!m_run[i]) begin
                    if (start[i] && !abort[i]) m_run[i] <= 1'b1;
                end else if (abort[i]) begin
                    m_run[i] <= 1'b0;
                    m_k[i]   <= 0;
                end else if (ready[i]) begin
                    if (m_k[i] == R[i] * C[i] * R[i] * C[i] - 1) begin
                        m_run[i]  <= 1'b0;
                        m_done[i] <= 1'b1;
                        m_k[i]    <= 0;
                    end else begin
                        m_k[i] <= m_k[i] + 1;
                    end
                end
            end
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int n, src, dst, sr, sc, dr, dc;
            n   = R[i] * C[i];
            src = m_k[i] / n;
            dst = m_k[i] % n;
            sr  = src / C[i];
            sc  = src % C[i];
            dr  = dst / C[i];
            dc  = dst % C[i];
            chk($sformatf("m%0d valid", i), o_valid[i], m_run[i]);
            chk($sformatf("m%0d busy", i), o_busy[i], m_run[i]);
            chk($sformatf("m%0d done", i), o_done[i], m_done[i]);
            chk($sformatf("m%0d addr", i), o_addr[i], (sr << CW[i]) | sc);
            chk($sformatf("m%0d idx", i), o_idx[i], dst);
            chk($sformatf("m%0d port", i), o_port[i], ref_port(sr, sc, dr, dc, R[i], C[i]));
            chk($sformatf("m%0d last", i), o_last[i], (m_run[i] && dst == n - 1) ? 1 : 0);
        end
    end

    int cap_a   [16];
    int r13_port[12];
    int r13_last[12];
    int r13_cnt = 0;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Start a run on instance i and follow it until done or the cycle budget runs out.
    // mode 0: ready high, 1: ready alternates starting high, 2: random ready.
    task automatic watch(input int i, input int mode, input int restart_at, input int budget,
                         output int nhs, output int nbusy, output int last_hs, output int done_at);
        nhs = 0;
        nbusy = 0;
        last_hs = -1;
        done_at = -1;
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        for (int c = 0; c < budget; c++) begin
            start[i] = (c == restart_at);
            case (mode)
                0:       ready[i] = 1'b1;
                1:       ready[i] = (c % 2 == 0);
                default: ready[i] = 1'($urandom_range(0, 1));
            endcase
            if (o_busy[i]) nbusy++;
            if (o_done[i]) begin
                done_at = c;
                break;
            end
            if (o_valid[i] && ready[i]) begin
                if (i == 0 && nhs < 16) cap_a[nhs] = int'(o_port[i]);
                if (i == 1 && o_addr[i] == 8'd7 && o_idx[i] < 8'd12) begin
                    r13_port[o_idx[i]] = int'(o_port[i]);
                    r13_last[o_idx[i]] = int'(o_last[i]);
                    r13_cnt++;
                end
                last_hs = c;
                nhs++;
            end
            step();
        end
        start[i] = 1'b0;
        ready[i] = 1'b0;
        chk("run reached done within budget", (done_at >= 0) ? 1 : 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int nhs, nbusy, last_hs, done_at, nd, lsum;

        #1 rst_n = 1'b0;
        step();
        step();
        chk("reset valid", o_valid[0], 0);
        chk("reset busy", o_busy[0], 0);
        chk("reset done", o_done[0], 0);
        chk("reset addr", o_addr[0], 0);
        chk("reset idx", o_idx[0], 0);
        chk("reset port", o_port[0], 0);
        chk("reset last", o_last[0], 0);
        rst_n = 1'b1;
        step();

        // 2x2, ready held high
        watch(0, 0, -1, 60, nhs, nbusy, last_hs, done_at);
        chk("full run handshakes", nhs, 16);
        chk("full run busy cycles", nbusy, 16);
        chk("full run done after last", done_at, last_hs + 1);
        chk("rtr0 dst0 port", cap_a[0], 0);
        chk("rtr0 dst1 port", cap_a[1], 3);
        chk("rtr0 dst2 port", cap_a[2], 2);
        chk("rtr0 dst3 port", cap_a[3], 3);
        chk("rtr3 dst0 port", cap_a[12], 4);
        chk("rtr3 dst1 port", cap_a[13], 1);
        chk("rtr3 dst2 port", cap_a[14], 4);
        chk("rtr3 dst3 port", cap_a[15], 0);
        step();
        chk("done is one cycle", o_done[0], 0);

        // 2x2, ready alternating: handshakes land on even cycles 0..30
        watch(0, 1, -1, 100, nhs, nbusy, last_hs, done_at);
        chk("stall run handshakes", nhs, 16);
        chk("stall run last handshake cycle", last_hs, 30);
        chk("stall run busy cycles", nbusy, 31);
        chk("stall run done cycle", done_at, 31);
        step();

        // 3x4 with random ready; pick out router {1,3}
        watch(1, 2, -1, 2000, nhs, nbusy, last_hs, done_at);
        chk("3x4 handshakes", nhs, 144);
        chk("3x4 rtr7 entries", r13_cnt, 12);
        chk("3x4 rtr7 dst3 port", r13_port[3], 1);
        chk("3x4 rtr7 dst8 port", r13_port[8], 4);
        chk("3x4 rtr7 dst7 port", r13_port[7], 0);
        chk("3x4 rtr7 dst11 port", r13_port[11], 2);
        lsum = 0;
        for (int d = 0; d < 12; d++) lsum += r13_last[d];
        chk("3x4 rtr7 last count", lsum, 1);
        chk("3x4 rtr7 last on dst11", r13_last[11], 1);
        step();

        // abort while the 5th entry is presented
        ready[0] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (4) step();
        chk("abort entry5 addr", o_addr[0], 1);
        chk("abort entry5 idx", o_idx[0], 0);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        chk("after abort valid", o_valid[0], 0);
        chk("after abort busy", o_busy[0], 0);
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            if (o_done[0]) nd++;
            step();
        end
        chk("no done after abort", nd, 0);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        chk("restart valid", o_valid[0], 1);
        chk("restart addr", o_addr[0], 0);
        chk("restart idx", o_idx[0], 0);
        repeat (20) step();
        ready[0] = 1'b0;
        chk("restarted run finished", o_busy[0], 0);

        // start pulsed mid-run must not restart the walk
        watch(0, 0, 3, 60, nhs, nbusy, last_hs, done_at);
        chk("start while busy handshakes", nhs, 16);
        chk("start while busy done", done_at, 16);
        step();

        // start together with abort in idle
        start[0] = 1'b1;
        abort[0] = 1'b1;
        step();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("start+abort stays idle busy", o_busy[0], 0);
        chk("start+abort stays idle valid", o_valid[0], 0);
        step();
        chk("start+abort still idle", o_busy[0], 0);

        // reset in the middle of a run
        ready[0] = 1'b1;
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (5) step();
        chk("mid run addr before reset", o_addr[0], 1);
        rst_n = 1'b0;
        #1;
        chk("async reset valid", o_valid[0], 0);
        chk("async reset busy", o_busy[0], 0);
        chk("async reset addr", o_addr[0], 0);
        chk("async reset idx", o_idx[0], 0);
        chk("async reset port", o_port[0], 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle after reset release", o_valid[0], 0);
        ready[0] = 1'b0;
        watch(0, 2, -1, 200, nhs, nbusy, last_hs, done_at);
        chk("run after reset handshakes", nhs, 16);

        // random traffic on both instances, checked by the model every cycle
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom_range(0, 19) == 0);
                abort[i] = ($urandom_range(0, (i == 0) ? 59 : 399) == 0);
                ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            ready[i] = 1'b0;
        end
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
